// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Turns the core's 6-bit internal op code plus register/immediate fields into a
// 32-bit RV32I instruction word. Legal words go into a DEPTH-entry output FIFO.
// Each popped word gets its byte address from a counter that starts at
// BASE_ADDR and steps by 4 per pop.
//
// Parameters:
//   DEPTH      output FIFO entries (power of two, >= 2)
//   BASE_ADDR  address carried by the first word popped after reset
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake (in_ready registered: count < DEPTH)
//   in_op, in_rs1/2, rd  internal op code and register fields
//   in_imm               full-value immediate (shift amount in [4:0])
//   out_valid/out_ready  encoded word handshake
//   out_instr, out_addr  encoded word and its byte address
//   err_illegal          one-cycle pulse after an illegal request is accepted
//   illegal_cnt          saturating count of accepted illegal requests
//
// Build option:
//   ENC_RANGE_CHECK_EN   when defined, an immediate that does not fit its field
//                        makes the request illegal. Otherwise the immediate is
//                        truncated to the field bits.
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_illegal,
    output logic [7:0]  illegal_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_ALU_REG = 7'b0110011;
    localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;

    logic [2:0]       w_f3;
    logic [31:0]      w_instr;
    logic             w_bad_op;
    logic             w_illegal;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [31:0]      w_head_nxt;

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [31:0]      r_out_instr;
    logic [31:0]      r_addr;
    logic             r_err;
    logic [7:0]       r_ill_cnt;

    assign w_f3 = in_op[2:0];

    // Op decode, field placement and op/funct3/alignment legality.
    always_comb begin
        w_instr  = '0;
        w_bad_op = 1'b0;
        if (in_op[3]) begin
            if (in_op[5]) begin
                w_instr  = {1'b0, in_op[4], 5'b0, in_rs2, in_rs1, w_f3, in_rd, OPC_ALU_REG};
                w_bad_op = in_op[4] && (w_f3 != 3'b000) && (w_f3 != 3'b101);
            end else begin
                w_bad_op = in_op[4] && (w_f3 != 3'b101);
                if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
                    w_instr = {1'b0, in_op[4], 5'b0, in_imm[4:0], in_rs1, w_f3, in_rd, OPC_ALU_IMM};
                end else begin
                    w_instr = {in_imm[11:0], in_rs1, w_f3, in_rd, OPC_ALU_IMM};
                end
            end
        end else if (in_op[4]) begin
            if (in_op[5]) begin
                w_instr  = {in_imm[11:5], in_rs2, in_rs1, w_f3, in_imm[4:0], OPC_STORE};
                w_bad_op = (w_f3 > 3'b010);
            end else begin
                w_instr  = {in_imm[11:0], in_rs1, w_f3, in_rd, OPC_LOAD};
                w_bad_op = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
        end else if (in_op[5]) begin
            w_instr  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_f3,
                        in_imm[4:1], in_imm[11], OPC_BRANCH};
            w_bad_op = (w_f3 == 3'b010) || (w_f3 == 3'b011) || in_imm[0];
        end else begin
            // op[5:3] == 000: jumps, upper-immediate ops and the all-zero NOP
            case (w_f3)
                3'b100:  w_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
                3'b101: begin
                    w_instr  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
                    w_bad_op = in_imm[0];
                end
                3'b010:  w_instr = {in_imm[31:12], in_rd, OPC_AUIPC};
                3'b110:  w_instr = {in_imm[31:12], in_rd, OPC_LUI};
                3'b000:  w_instr = '0;
                default: w_bad_op = 1'b1;
            endcase
        end
    end

`ifdef ENC_RANGE_CHECK_EN
    logic w_fit12;
    logic w_fit13;
    logic w_fit21;
    logic w_bad_rng;

    // Signed-field fit: every bit above the field's sign bit copies the sign.
    assign w_fit12 = (in_imm[31:11] == {21{in_imm[11]}});
    assign w_fit13 = (in_imm[31:12] == {20{in_imm[12]}});
    assign w_fit21 = (in_imm[31:20] == {12{in_imm[20]}});

    // Immediate range check, chosen by the same op classes as the encoder.
    always_comb begin
        w_bad_rng = 1'b0;
        if (in_op[3]) begin
            if (!in_op[5]) begin
                if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
                    w_bad_rng = (in_imm[31:5] != 27'd0);
                end else begin
                    w_bad_rng = !w_fit12;
                end
            end
        end else if (in_op[4]) begin
            w_bad_rng = !w_fit12;
        end else if (in_op[5]) begin
            w_bad_rng = !w_fit13;
        end else begin
            case (w_f3)
                3'b100:         w_bad_rng = !w_fit12;
                3'b101:         w_bad_rng = !w_fit21;
                3'b010, 3'b110: w_bad_rng = (in_imm[11:0] != 12'd0);
                default:        w_bad_rng = 1'b0;
            endcase
        end
    end

    assign w_illegal = w_bad_op || w_bad_rng;
`else
    assign w_illegal = w_bad_op;
`endif

    assign w_accept = in_valid && r_in_ready;
    assign w_push   = w_accept && !w_illegal;
    assign w_pop    = r_out_valid && out_ready;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;

    // The next head is the word being written now when it lands in the head slot.
    assign w_head_nxt = (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? w_instr : r_mem[w_rd_ptr_nxt];

    // FIFO storage needs no reset; the count and pointers define which slots are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_instr;
        end
    end

    // FIFO control, output register, address counter and illegal tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_addr      <= BASE_ADDR;
            r_err       <= 1'b0;
            r_ill_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_in_ready  <= (w_cnt_nxt < CNT_W'(DEPTH));
            r_out_valid <= (w_cnt_nxt != '0);
            if (w_cnt_nxt != '0) begin
                r_out_instr <= w_head_nxt;
            end
            if (w_pop) begin
                r_addr <= r_addr + 32'd4;
            end
            r_err <= w_accept && w_illegal;
            if (w_accept && w_illegal && (r_ill_cnt != 8'hFF)) begin
                r_ill_cnt <= r_ill_cnt + 8'd1;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_addr    = r_addr;
    assign err_illegal = r_err;
    assign illegal_cnt = r_ill_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder. A behavioural model builds each
// expected instruction word with integer arithmetic from the RV32I field rules.
// A queue stands in for the FIFO and a plain counter tracks the address.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err_illegal;
    logic [7:0]  illegal_cnt;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .err_illegal (err_illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic [31:0] q[$];
    logic [31:0] exp_addr;
    int          exp_cnt;
    bit          exp_err;
    bit          exp_rdy;

    // Reference encoder: integer field arithmetic following the op map.
    function automatic void ref_encode(input logic [5:0] op, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [4:0] rd,
                                       input logic [31:0] imm,
                                       output bit legal, output logic [31:0] w);
        int unsigned u, f3, r1, r2, d, s;
        longint      si;
        bit          fits, rc;
        u = imm; f3 = op % 8; r1 = rs1; r2 = rs2; d = rd;
        si = longint'($signed(imm));
`ifdef ENC_RANGE_CHECK_EN
        rc = 1'b1;
`else
        rc = 1'b0;
`endif
        legal = 1'b1; fits = 1'b1; s = 0;
        if (op == 6'd0) begin
            s = 0;
        end else if (op[3]) begin
            if (op[5]) begin
                if (op[4] && f3 != 0 && f3 != 5) legal = 1'b0;
                s = (op[4] ? (1 << 30) : 0) + (r2 << 20) + (r1 << 15) + (f3 << 12) + (d << 7) + 'h33;
            end else begin
                if (op[4] && f3 != 5) legal = 1'b0;
                if (f3 == 1 || f3 == 5) begin
                    s = ((op[4] ? 1024 : 0) + u % 32) << 20;
                    fits = (u < 32);
                end else begin
                    s = (u % 4096) << 20;
                    fits = (si >= -2048 && si <= 2047);
                end
                s = s + (r1 << 15) + (f3 << 12) + (d << 7) + 'h13;
            end
        end else if (op[4] && !op[5]) begin
            if (f3 == 3 || f3 == 6 || f3 == 7) legal = 1'b0;
            s = ((u % 4096) << 20) + (r1 << 15) + (f3 << 12) + (d << 7) + 'h03;
            fits = (si >= -2048 && si <= 2047);
        end else if (op[4]) begin
            if (f3 > 2) legal = 1'b0;
            s = (((u / 32) % 128) << 25) + (r2 << 20) + (r1 << 15) + (f3 << 12) + ((u % 32) << 7) + 'h23;
            fits = (si >= -2048 && si <= 2047);
        end else if (op[5]) begin
            if (f3 == 2 || f3 == 3 || (u % 2) == 1) legal = 1'b0;
            s = (((u / 4096) % 2) << 31) + (((u / 32) % 64) << 25) + (r2 << 20) + (r1 << 15)
              + (f3 << 12) + (((u / 2) % 16) << 8) + (((u / 2048) % 2) << 7) + 'h63;
            fits = (si >= -4096 && si <= 4095);
        end else begin
            case (f3)
                4: begin
                    s = ((u % 4096) << 20) + (r1 << 15) + (d << 7) + 'h67;
                    fits = (si >= -2048 && si <= 2047);
                end
                5: begin
                    if ((u % 2) == 1) legal = 1'b0;
                    s = (((u >> 20) % 2) << 31) + (((u / 2) % 1024) << 21) + (((u >> 11) % 2) << 20)
                      + (((u >> 12) % 256) << 12) + (d << 7) + 'h6F;
                    fits = (si >= -1048576 && si <= 1048575);
                end
                2: begin
                    s = ((u / 4096) << 12) + (d << 7) + 'h17;
                    fits = ((u % 4096) == 0);
                end
                6: begin
                    s = ((u / 4096) << 12) + (d << 7) + 'h37;
                    fits = ((u % 4096) == 0);
                end
                default: legal = 1'b0;
            endcase
        end
        if (rc && !fits) legal = 1'b0;
        w = legal ? 32'(s) : 32'h0;
    endfunction

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0:       return 32'($signed($urandom_range(0, 80)) - 40);
            1:       return 32'($urandom);
            2:       return 32'($urandom) & 32'hFFFF_F000;
            default: return 32'($urandom_range(0, 31));
        endcase
    endfunction

    // One clock: drive at the negedge, check the head and advance the model.
    task automatic step(input bit v, input logic [5:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] imm, input bit ordy);
        bit          legal, acc, pop;
        logic [31:0] w;
        @(negedge clk);
        in_valid = v; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_imm = imm; out_ready = ordy;
        acc = v && exp_rdy;
        pop = (q.size() != 0) && ordy;
        if (q.size() != 0) begin
            n_checks++;
            if (out_instr !== q[0]) begin
                n_fail++;
                $display("FAIL head_instr: got %h expected %h", out_instr, q[0]);
            end
            n_checks++;
            if (out_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL head_addr: got %h expected %h", out_addr, exp_addr);
            end
        end
        ref_encode(op, rs1, rs2, rd, imm, legal, w);
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q.pop_front());
            exp_addr += 32'd4;
        end
        exp_err = 1'b0;
        if (acc) begin
            if (legal) begin
                q.push_back(w);
            end else begin
                exp_err = 1'b1;
                if (exp_cnt < 255) exp_cnt++;
            end
        end
        exp_rdy = (q.size() < DEPTH);
        n_checks++;
        if (out_valid !== (q.size() != 0)) begin
            n_fail++;
            $display("FAIL out_valid: got %b expected %b", out_valid, q.size() != 0);
        end
        n_checks++;
        if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
        end
        n_checks++;
        if (err_illegal !== exp_err) begin
            n_fail++;
            $display("FAIL err_illegal: got %b expected %b", err_illegal, exp_err);
        end
        n_checks++;
        if (illegal_cnt !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL illegal_cnt: got %0d expected %0d", illegal_cnt, exp_cnt);
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, ordy);
    endtask

    task automatic model_reset();
        q.delete();
        exp_addr = BASE; exp_cnt = 0; exp_err = 1'b0; exp_rdy = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || err_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_flags: got v=%b r=%b e=%b expected 0 0 0", tag, out_valid, in_ready, err_illegal);
        end
        n_checks++;
        if (out_addr !== BASE || illegal_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL %s_addr_cnt: got %h/%0d expected %h/0", tag, out_addr, illegal_cnt, BASE);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: got %b expected 1", in_ready);
        end
        exp_rdy = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && q.size() != 0; i++) idle(1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0;
        in_rd = '0; in_imm = '0; out_ready = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        n_checks++;
        if (out_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_instr: got %h expected 00000000", out_instr);
        end
        release_reset();
    endtask

    task automatic test_directed();
        step(1'b1, 6'b101000, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
        n_checks++;
        if (out_instr !== 32'h002081B3 || out_addr !== BASE) begin
            n_fail++;
            $display("FAIL add_word: got %h@%h expected 002081b3@%h", out_instr, out_addr, BASE);
        end
        idle(1'b1);
        step(1'b1, 6'b001000, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF, 1'b1);
        n_checks++;
        if (out_instr !== 32'hFFF00293) begin
            n_fail++;
            $display("FAIL addi_word: got %h expected fff00293", out_instr);
        end
        step(1'b1, 6'b000110, 5'd0, 5'd0, 5'd1, 32'h1234_5000, 1'b1);
        n_checks++;
        if (out_instr !== 32'h123450B7) begin
            n_fail++;
            $display("FAIL lui_word: got %h expected 123450b7", out_instr);
        end
        drain();
    endtask

    task automatic test_illegal();
        step(1'b1, 6'b110011, 5'd1, 5'd2, 5'd0, 32'd4, 1'b1);
        n_checks++;
        if (err_illegal !== 1'b1 || illegal_cnt !== 8'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_illegal: got e=%b cnt=%0d v=%b expected 1 1 0", err_illegal, illegal_cnt, out_valid);
        end
        idle(1'b1);
        n_checks++;
        if (err_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse_width: got %b expected 0", err_illegal);
        end
    endtask

    task automatic test_range();
        step(1'b1, 6'b001000, 5'd0, 5'd0, 5'd0, 32'h0000_0800, 1'b1);
`ifdef ENC_RANGE_CHECK_EN
        n_checks++;
        if (err_illegal !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_range: got e=%b v=%b expected 1 0", err_illegal, out_valid);
        end
`else
        n_checks++;
        if (out_instr !== 32'h80000013 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL addi_trunc: got %h v=%b expected 80000013 1", out_instr, out_valid);
        end
`endif
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a0;
        drain();
        a0 = exp_addr;
        for (int i = 0; i < 4; i++) step(1'b1, 6'b101000, 5'd1, 5'd2, 5'(i + 1), 32'd0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: got %b expected 0", in_ready);
        end
        step(1'b1, 6'b101000, 5'd1, 5'd2, 5'd9, 32'd0, 1'b1);
        step(1'b1, 6'b101000, 5'd1, 5'd2, 5'd9, 32'd0, 1'b1);
        drain();
        n_checks++;
        if (out_addr !== a0 + 32'd20) begin
            n_fail++;
            $display("FAIL b2b_final_addr: got %h expected %h", out_addr, a0 + 32'd20);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)), 5'($urandom),
                 5'($urandom), 5'($urandom), rand_imm(), ($urandom_range(0, 2) != 0));
        end
        drain();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) step(1'b1, 6'b000001, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
        idle(1'b1);
        n_checks++;
        if (illegal_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL cnt_saturate: got %0d expected 255", illegal_cnt);
        end
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 3; i++) step(1'b1, 6'b001000, 5'd2, 5'd0, 5'(i + 4), 32'(i), 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        model_reset();
        check_reset_values("flush");
        #3;
        release_reset();
        step(1'b1, 6'b101000, 5'd7, 5'd8, 5'd9, 32'd0, 1'b1);
        n_checks++;
        if (out_addr !== BASE || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_addr: got %h v=%b expected %h 1", out_addr, out_valid, BASE);
        end
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_illegal();
        test_range();
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
